// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and default sizing for the sequence-detector scan controller.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } scan_state_t;

    localparam int DEF_N = 6;
    localparam int DEF_W = 16;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Front-end handshake and result bus between the register block and the scan controller.
interface seq_scan_ctrl_if
    import seq_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(W);

    logic          start;
    logic          abort;
    logic [W-1:0]  data_in;
    logic [N-1:0]  pat_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] hit_count;
    logic          hit_found;
    logic [PW-1:0] first_hit_pos;

    modport master (
        output start, abort, data_in, pat_in,
        input  busy, done, hit_count, hit_found, first_hit_pos
    );

    modport slave (
        input  start, abort, data_in, pat_in,
        output busy, done, hit_count, hit_found, first_hit_pos
    );

endinterface

// File: rtl/seq_scan_ctrl.sv
// Streams a latched word MSB-first into a serial sequence detector, counting
// matches and recording where the first one ends.
module seq_scan_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           reset_n,
    seq_scan_ctrl_if.slave bus,
    output logic           det_a,
    output logic [N-1:0]   det_seq,
    output logic           det_rst_n,
    input  logic           det_valid
);
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(W);
    localparam logic [PW:0]   K_LAST   = (PW + 1)'(W - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(W - 1);

    scan_state_t   state_q, state_d;
    logic [PW:0]   k_q, k_d;
    logic [W-1:0]  word_q, word_d;
    logic [N-1:0]  pat_q, pat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] hit_count_q, hit_count_d;
    logic          hit_found_q, hit_found_d;
    logic [PW-1:0] first_hit_pos_q, first_hit_pos_d;
    logic          det_a_q, det_a_d;
    logic          det_rst_n_q, det_rst_n_d;

    logic          hit;
    logic [PW-1:0] hit_pos;
    logic [PW:0]   k_m1;

    // A hit seen in SHIFT cycle k belongs to the match ending on the previous bit.
    assign k_m1 = k_q - 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d         = state_q;
        k_d             = k_q;
        word_d          = word_q;
        pat_d           = pat_q;
        busy_d          = 1'b0;
        done_d          = 1'b0;
        det_a_d         = 1'b0;
        det_rst_n_d     = 1'b1;
        hit_count_d     = hit_count_q;
        hit_found_d     = hit_found_q;
        first_hit_pos_d = first_hit_pos_q;
        hit             = 1'b0;
        hit_pos         = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    word_d          = bus.data_in;
                    pat_d           = bus.pat_in;
                    hit_count_d     = '0;
                    hit_found_d     = 1'b0;
                    first_hit_pos_d = '0;
                    busy_d          = 1'b1;
                    det_rst_n_d     = 1'b0;
                    state_d         = CLEAR;
                end
            end
            CLEAR: begin
                // The word register doubles as the shifter; its MSB is always the next bit out.
                det_a_d = word_q[W-1];
                word_d  = word_q << 1;
                k_d     = '0;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (det_valid && (k_q != '0)) begin
                    hit     = 1'b1;
                    hit_pos = k_m1[PW-1:0];
                end
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    det_a_d = word_q[W-1];
                    word_d  = word_q << 1;
                    k_d     = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (det_valid) begin
                    hit     = 1'b1;
                    hit_pos = POS_LAST;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (hit) begin
            hit_count_d = hit_count_q + 1'b1;
            if (!hit_found_q) begin
                hit_found_d     = 1'b1;
                first_hit_pos_d = hit_pos;
            end
        end

        if (bus.abort && (state_q inside {CLEAR, SHIFT, DRAIN})) begin
            state_d         = IDLE;
            busy_d          = 1'b0;
            done_d          = 1'b0;
            det_a_d         = 1'b0;
            det_rst_n_d     = 1'b0;
            hit_count_d     = '0;
            hit_found_d     = 1'b0;
            first_hit_pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            k_q             <= '0;
            word_q          <= '0;
            pat_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            hit_count_q     <= '0;
            hit_found_q     <= 1'b0;
            first_hit_pos_q <= '0;
            det_a_q         <= 1'b0;
            det_rst_n_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q         <= state_d;
            k_q             <= k_d;
            word_q          <= word_d;
            pat_q           <= pat_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            hit_count_q     <= hit_count_d;
            hit_found_q     <= hit_found_d;
            first_hit_pos_q <= first_hit_pos_d;
            det_a_q         <= det_a_d;
            det_rst_n_q     <= det_rst_n_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.hit_count     = hit_count_q;
    assign bus.hit_found     = hit_found_q;
    assign bus.first_hit_pos = first_hit_pos_q;
    assign det_a             = det_a_q;
    assign det_seq           = pat_q;
    assign det_rst_n         = det_rst_n_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl driving a behavioural serial sequence detector.
module tb_seq_scan_ctrl;
    import seq_ctrl_pkg::*;

    localparam int N  = DEF_N;
    localparam int W  = DEF_W;
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(W);

    typedef struct {
        int cnt;
        int found;
        int pos;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         det_a;
    logic [N-1:0] det_seq;
    logic         det_rst_n;
    logic         det_valid;

    int   n_checks;
    int   n_fail;
    int   done_seen;
    exp_t sb[$];

    seq_scan_ctrl_if #(.N(N), .W(W)) bus ();

    seq_scan_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .det_a     (det_a),
        .det_seq   (det_seq),
        .det_rst_n (det_rst_n),
        .det_valid (det_valid)
    );

    // Detector: shift history in, flag once N bits are held and they equal the pattern.
    logic [N-1:0] dh_q;
    int           fill_q;

    always_ff @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            dh_q   <= '0;
            fill_q <= 0;
        end else begin
            dh_q <= {dh_q[N-2:0], det_a};
            if (fill_q < N) fill_q <= fill_q + 1;
        end
    end

    assign det_valid = (fill_q == N) && (dh_q == det_seq);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Matches ending at bit index <= last, bit 0 being the word's MSB.
    function automatic exp_t model(input logic [W-1:0] w, input logic [N-1:0] p, input int last);
        exp_t r;
        logic [N-1:0] win;
        r.cnt = 0; r.found = 0; r.pos = 0;
        for (int e = N - 1; e <= last; e++) begin
            win = w[W-1-(e-N+1) -: N];
            if (win == p) begin
                if (r.found == 0) r.pos = e;
                r.found = 1;
                r.cnt++;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("hit_count", 32'(bus.hit_count), e.cnt);
                check("hit_found", 32'(bus.hit_found), e.found);
                check("first_hit_pos", 32'(bus.first_hit_pos), e.pos);
                check("busy_in_done", 32'(bus.busy), 0);
            end
        end
    end

    task automatic start_scan(input logic [W-1:0] w, input logic [N-1:0] p);
        sb.push_back(model(w, p, W - 1));
        bus.data_in = w;
        bus.pat_in  = p;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns at #1 after the edge that raised done; lat counts edges after the start edge.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic to_idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   lat;
        int   seen0;
        exp_t part;
        logic [W-1:0] w;
        logic [N-1:0] p;

        n_checks = 0; n_fail = 0; done_seen = 0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.data_in = '0; bus.pat_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_hit_count", 32'(bus.hit_count), 0);
        check("rst_det_rst_n", 32'(det_rst_n), 0);
        check("rst_det_seq", 32'(det_seq), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_det_rst_n", 32'(det_rst_n), 1);

        // Alternating pattern over alternating word; CLEAR + W SHIFT + DRAIN before DONE.
        start_scan(16'hAAAA, 6'b101010);
        check("clear_busy", 32'(bus.busy), 1);
        check("clear_det_rst_n", 32'(det_rst_n), 0);
        check("clear_det_seq", 32'(det_seq), 32'(6'b101010));
        wait_done(lat);
        check("latency", lat, W + 2);
        to_idle_cycle();
        check("done_one_cycle", 32'(bus.done), 0);
        check("held_hit_count", 32'(bus.hit_count), 6);

        // No-match word: done still pulses exactly once.
        seen0 = done_seen;
        start_scan(16'h0F0F, 6'b111111);
        wait_done(lat);
        repeat (4) to_idle_cycle();
        check("done_once", done_seen - seen0, 1);

        // All-ones then back-to-back scan; flush must stop history carrying across words.
        start_scan(16'hFFFF, 6'b111111);
        wait_done(lat);
        to_idle_cycle();
        start_scan(16'h07FF, 6'b111111);
        wait_done(lat);
        check("b2b_latency", lat, W + 2);
        to_idle_cycle();

        // Abort in SHIFT k=8: next cycle idle, detector reset for one cycle, no done.
        seen0 = done_seen;
        start_scan(16'hAAAA, 6'b101010);
        repeat (9) to_idle_cycle();
        part = model(16'hAAAA, 6'b101010, 6);
        check("pre_abort_busy", 32'(bus.busy), 1);
        check("pre_abort_count", 32'(bus.hit_count), part.cnt);
        bus.abort = 1'b1;
        to_idle_cycle();
        bus.abort = 1'b0;
        void'(sb.pop_back());
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_det_rst_n", 32'(det_rst_n), 0);
        check("abort_hit_count", 32'(bus.hit_count), 0);
        check("abort_hit_found", 32'(bus.hit_found), 0);
        to_idle_cycle();
        check("abort_det_rst_n_rel", 32'(det_rst_n), 1);
        repeat (W + 4) to_idle_cycle();
        check("abort_no_done", done_seen - seen0, 0);

        // Start during SHIFT with a different word must not disturb the scan.
        start_scan(16'hAAAA, 6'b101010);
        repeat (5) to_idle_cycle();
        bus.data_in = 16'hFFFF;
        bus.pat_in  = 6'b111111;
        bus.start   = 1'b1;
        to_idle_cycle();
        bus.start = 1'b0;
        check("ignored_start_det_seq", 32'(det_seq), 32'(6'b101010));
        wait_done(lat);
        to_idle_cycle();

        // Asynchronous reset at SHIFT k=10, then a clean scan.
        start_scan(16'hAAAA, 6'b101010);
        repeat (11) to_idle_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_hit_count", 32'(bus.hit_count), 0);
        check("arst_hit_found", 32'(bus.hit_found), 0);
        check("arst_first_pos", 32'(bus.first_hit_pos), 0);
        check("arst_det_a", 32'(det_a), 0);
        check("arst_det_seq", 32'(det_seq), 0);
        check("arst_det_rst_n", 32'(det_rst_n), 0);
        @(negedge clk);
        reset_n = 1'b1;
        to_idle_cycle();
        check("post_rst_det_rst_n", 32'(det_rst_n), 1);
        start_scan(16'hAAAA, 6'b101010);
        wait_done(lat);
        to_idle_cycle();

        // Random words, pattern sometimes lifted from the word to force hits.
        for (int t = 0; t < 6; t++) begin
            w = W'($urandom);
            if (t % 2 == 0) p = w[W-1-int'($urandom_range(0, W - N)) -: N];
            else            p = N'($urandom);
            start_scan(w, p);
            wait_done(lat);
            to_idle_cycle();
        end

        repeat (3) to_idle_cycle();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end by 200000");
        $fatal(1, "timeout");
    end

endmodule
